mmio_dma_master: RTL and testbench

- Bus initiator for the core's memory-mapped peripheral bus (we/wd/addr/rd, single-cycle registered read data).
- Copies or fills a block of words between bus addresses without CPU involvement. Typical uses: streaming a RAM buffer out to PIO/GPIO data registers, or snapshotting peripheral registers into RAM.
- Sits beside the CPU data port. An external arbiter grants the bus; this block only drives it while busy.

---
 rtl/mmio_dma_master_if.sv | 16 +
 rtl/mmio_dma_master.sv | 167 ++++++++++++++++
 tb/tb_mmio_dma_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_dma_master_if.sv
// mmio_dma_master_if
//   Peripheral bus bundle: write enable, byte address, write data,
//   and registered read data.
//   master modport : drives we/addr/wd and samples rd (the DMA engine).
//   slave  modport : samples we/addr/wd and drives rd (bus fabric / responder).
interface mmio_dma_master_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    modport master (output we, output addr, output wd, input rd);
    modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/mmio_dma_master.sv
// mmio_dma_master
//   Bus initiator that copies a block of words from src to dst, or fills
//   dst with a constant, without CPU involvement.
//   Ports:
//     clk, rst_n       clock / asynchronous active-low reset
//     start            one-cycle job request, only looked at in IDLE
//     mode_fill        0 = copy, 1 = fill with fill_val (no reads)
//     src_inc/dst_inc  advance pointer by one word per transfer
//     src_addr/dst_addr/fill_val/len   job descriptor, latched on start
//     abort            level-sensitive stop request
//     busy/done/err/aborted/words_done status
//     bus              peripheral bus (master modport)
module mmio_dma_master #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_fill,
    input  logic             src_inc,
    input  logic             dst_inc,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] fill_val,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done,
    mmio_dma_master_if.master bus
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_src_ptr;
    logic [WIDTH-1:0] r_dst_ptr;
    logic [WIDTH-1:0] r_fill_val;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_words_done;
    logic             r_mode_fill;
    logic             r_src_inc;
    logic             r_dst_inc;
    logic             r_err;
    logic             r_aborted;

    logic             w_misalign;
    logic             w_last;

    // Source alignment is irrelevant in fill mode since nothing is read.
    assign w_misalign = (|dst_addr[1:0]) | (~mode_fill & (|src_addr[1:0]));
    assign w_last     = (r_remaining == LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misalign || (len == '0)) w_next = S_DONE;
                    else if (mode_fill)            w_next = S_WRITE;
                    else                           w_next = S_READ;
                end
            end
            S_READ:  w_next = abort ? S_DONE : S_WRITE;
            S_WRITE: begin
                if (w_last || abort)  w_next = S_DONE;
                else if (r_mode_fill) w_next = S_WRITE;
                else                  w_next = S_READ;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state flops so an async reset
    // drops the bus write enable without waiting for a clock edge.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        unique case (r_state)
            S_READ: begin
                busy     = 1'b1;
                bus.addr = r_src_ptr;
            end
            S_WRITE: begin
                busy     = 1'b1;
                bus.we   = 1'b1;
                bus.addr = r_dst_ptr;
                // Copy data is the read returned this cycle, forwarded unregistered.
                bus.wd   = r_mode_fill ? r_fill_val : bus.rd;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Job descriptor, pointers and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_fill_val   <= '0;
            r_remaining  <= '0;
            r_words_done <= '0;
            r_mode_fill  <= 1'b0;
            r_src_inc    <= 1'b0;
            r_dst_inc    <= 1'b0;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr    <= src_addr;
                        r_dst_ptr    <= dst_addr;
                        r_fill_val   <= fill_val;
                        r_remaining  <= len;
                        r_mode_fill  <= mode_fill;
                        r_src_inc    <= src_inc;
                        r_dst_inc    <= dst_inc;
                        r_words_done <= '0;
                        r_err        <= w_misalign;
                        r_aborted    <= 1'b0;
                    end
                end
                S_READ: begin
                    if (abort) r_aborted <= 1'b1;
                end
                S_WRITE: begin
                    r_words_done <= r_words_done + LEN_W'(1);
                    r_remaining  <= r_remaining - LEN_W'(1);
                    if (r_src_inc) r_src_ptr <= r_src_ptr + STEP;
                    if (r_dst_inc) r_dst_ptr <= r_dst_ptr + STEP;
                    if (abort)     r_aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err        = r_err;
    assign aborted    = r_aborted;
    assign words_done = r_words_done;

endmodule

// File: tb/tb_mmio_dma_master.sv
module tb_mmio_dma_master;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start, mode_fill, src_inc, dst_inc, abort;
    logic [WIDTH-1:0] src_addr, dst_addr, fill_val;
    logic [LEN_W-1:0] len;
    logic             busy, done, err, aborted;
    logic [LEN_W-1:0] words_done;

    mmio_dma_master_if #(.WIDTH(WIDTH)) bif ();

    mmio_dma_master #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode_fill  (mode_fill),
        .src_inc    (src_inc),
        .dst_inc    (dst_inc),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .fill_val   (fill_val),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .aborted    (aborted),
        .words_done (words_done),
        .bus        (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read responder: data = {A5A5, addr[15:0]}
    always @(posedge clk) begin
        if (!bif.we) bif.rd <= {16'hA5A5, bif.addr[15:0]};
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          rel;
    } wr_exp_t;

    typedef struct {
        int words;
        bit e;
        bit ab;
        int rel;
        int busy_cyc;
    } done_exp_t;

    wr_exp_t   wq[$];
    done_exp_t dq[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input int rel);
        wr_exp_t e;
        e.addr = a; e.data = d; e.rel = rel;
        wq.push_back(e);
    endtask

    task automatic exp_done(input int words, input bit e, input bit ab, input int rel, input int bc);
        done_exp_t x;
        x.words = words; x.e = e; x.ab = ab; x.rel = rel; x.busy_cyc = bc;
        dq.push_back(x);
    endtask

    // Monitor: pops expectations whenever the DUT writes or signals done.
    initial begin
        int bc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0;
            end else begin
                int rel;
                rel = cyc - t0 + 1;
                if (busy) bc++;
                if (bif.we) begin
                    if (wq.size() == 0) chk("unexpected_write", bif.addr, 0);
                    else begin
                        wr_exp_t e;
                        e = wq.pop_front();
                        chk("wr_addr", bif.addr, e.addr);
                        chk("wr_data", bif.wd, e.data);
                        chk("wr_cycle", rel, e.rel);
                    end
                end
                if (done) begin
                    if (dq.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        done_exp_t x;
                        x = dq.pop_front();
                        chk("done_words", words_done, x.words);
                        chk("done_err", err, x.e);
                        chk("done_aborted", aborted, x.ab);
                        chk("done_cycle", rel, x.rel);
                        chk("busy_cycles", bc, x.busy_cyc);
                        chk("done_bus_we", bif.we, 0);
                        chk("done_bus_addr", bif.addr, 0);
                    end
                    bc = 0;
                end
            end
        end
    end

    task automatic start_job(input bit fm, input bit si, input bit di, input logic [31:0] s,
                             input logic [31:0] d, input logic [31:0] fv, input logic [15:0] l);
        @(negedge clk);
        mode_fill = fm; src_inc = si; dst_inc = di;
        src_addr = s; dst_addr = d; fill_val = fv; len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; mode_fill = 0; src_inc = 0; dst_inc = 0; abort = 0;
        src_addr = '0; dst_addr = '0; fill_val = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_words", words_done, 0);
        chk("rst_we", bif.we, 0);
        chk("rst_addr", bif.addr, 0);
        chk("rst_wd", bif.wd, 0);

        // Copy 3 words, both pointers increment
        exp_wr(32'h200, 32'hA5A5_0100, 2);
        exp_wr(32'h204, 32'hA5A5_0104, 4);
        exp_wr(32'h208, 32'hA5A5_0108, 6);
        exp_done(3, 0, 0, 7, 6);
        start_job(0, 1, 1, 32'h100, 32'h200, 32'h0, 16'd3);
        wait_done();

        // Fill to fixed LED register; src misaligned but ignored in fill mode
        for (int i = 1; i <= 4; i++) exp_wr(32'h14, 32'hDEAD_BEEF, i);
        exp_done(4, 0, 0, 5, 4);
        start_job(1, 1, 0, 32'h3, 32'h14, 32'hDEAD_BEEF, 16'd4);
        wait_done();

        // len == 0
        exp_done(0, 0, 0, 1, 0);
        start_job(0, 1, 1, 32'h100, 32'h200, 32'h0, 16'd0);
        wait_done();

        // Misaligned destination
        exp_done(0, 1, 0, 1, 0);
        start_job(0, 1, 1, 32'h100, 32'h202, 32'h0, 16'd3);
        wait_done();
        chk("err_sticky", err, 1);

        // Abort in 3rd READ
        exp_wr(32'h400, 32'hA5A5_0300, 2);
        exp_wr(32'h404, 32'hA5A5_0304, 4);
        exp_done(2, 0, 1, 6, 5);
        start_job(0, 1, 1, 32'h300, 32'h400, 32'h0, 16'd5);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done();
        chk("aborted_sticky", aborted, 1);

        // Abort in 3rd WRITE
        exp_wr(32'h400, 32'hA5A5_0300, 2);
        exp_wr(32'h404, 32'hA5A5_0304, 4);
        exp_wr(32'h408, 32'hA5A5_0308, 6);
        exp_done(3, 0, 1, 7, 6);
        start_job(0, 1, 1, 32'h300, 32'h400, 32'h0, 16'd5);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done();

        // Start while busy is ignored; new job clears aborted
        exp_wr(32'h600, 32'hA5A5_0500, 2);
        exp_wr(32'h600, 32'hA5A5_0504, 4);
        exp_done(2, 0, 0, 5, 4);
        start_job(0, 1, 0, 32'h500, 32'h600, 32'h0, 16'd2);
        @(negedge clk);
        start = 1'b1; len = 16'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Reset during the 2nd WRITE
        exp_wr(32'h800, 32'hA5A5_0700, 2);
        start_job(0, 1, 1, 32'h700, 32'h800, 32'h0, 16'd3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", bif.we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_words", words_done, 0);
        chk("arst_addr", bif.addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_done", done, 0);

        // Recovery: single-word copy
        exp_wr(32'h900, 32'hA5A5_0880, 2);
        exp_done(1, 0, 0, 3, 2);
        start_job(0, 1, 1, 32'h880, 32'h900, 32'h0, 16'd1);
        wait_done();

        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
